// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester (CPU, DMA) arbiter over a 16-bit synchronous ROM,
// assembling byte-swapped halfwords into 16- or 32-bit read responses.
//
// Ports:
//   CLK, RESET_N               clock, synchronous active-low reset
//   cpu_req/addr/word          CPU request, halfword start address, 1 = 32-bit access
//   dma_req/addr/word          DMA request, same meaning
//   cpu_done/rdata             CPU one-cycle completion pulse and read data
//   dma_done/rdata             DMA one-cycle completion pulse and read data
//   rom_en, rom_addr           registered ROM read enable and halfword address
//   rom_dout                   ROM data, one cycle after rom_en/rom_addr
//   busy                       high whenever a transaction is in flight
//
// Build option: define ROM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise the CPU always wins.
module rom_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_word,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_word,
   output logic              cpu_done,
   output logic [31:0]       cpu_rdata,
   output logic              dma_done,
   output logic [31:0]       dma_rdata,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_dout,
   output logic              busy
);
   typedef enum logic [2:0] {IDLE, ISSUE, CAP_LO, CAP_HI, RESP} state_t;
   state_t state_q, state_d;
   logic owner_q, owner_d;
   logic word_q, word_d;
   logic rom_en_q, rom_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rom_addr_q, rom_addr_d;
   logic [15:0] lo_q, lo_d, hi_q, hi_d;
   logic [15:0] swapped;
   logic [31:0] rdata;
   logic grant_dma;
   // owner encoding: 0 = CPU, 1 = DMA
`ifdef ROM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   // on a tie, grant whoever did not win last time
   assign grant_dma = dma_req & (~cpu_req | ~last_q);
`else
   assign grant_dma = dma_req & ~cpu_req;
`endif
   // ROM halfwords are stored big-endian; responses are little-endian
   assign swapped = {rom_dout[7:0], rom_dout[15:8]};
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      word_d     = word_q;
      addr_d     = addr_q;
      rom_addr_d = rom_addr_q;
      rom_en_d   = rom_en_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: if (cpu_req || dma_req) begin
            owner_d    = grant_dma;
            word_d     = grant_dma ? dma_word : cpu_word;
            addr_d     = grant_dma ? dma_addr : cpu_addr;
            rom_addr_d = addr_d;
            rom_en_d   = 1'b1;
            state_d    = ISSUE;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_d     = grant_dma;
`endif
         end
         ISSUE: begin
            // second halfword is requested back-to-back; address wraps at the top
            rom_addr_d = word_q ? addr_q + ADDR_W'(1) : rom_addr_q;
            rom_en_d   = word_q;
            state_d    = CAP_LO;
         end
         CAP_LO: begin
            lo_d     = swapped;
            rom_en_d = 1'b0;
            state_d  = word_q ? CAP_HI : RESP;
         end
         CAP_HI: begin
            hi_d    = swapped;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         word_q     <= 1'b0;
         addr_q     <= '0;
         rom_addr_q <= '0;
         rom_en_q   <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         rom_addr_q <= rom_addr_d;
         rom_en_q   <= rom_en_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end
   assign rdata     = word_q ? {hi_q, lo_q} : {16'h0, lo_q};
   assign busy      = state_q != IDLE;
   assign cpu_done  = (state_q == RESP) & ~owner_q;
   assign dma_done  = (state_q == RESP) & owner_q;
   assign cpu_rdata = cpu_done ? rdata : 32'h0;
   assign dma_rdata = dma_done ? rdata : 32'h0;
   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized self-checking bench for rom_arbiter against a
// transaction-level model of grant, latency, ROM address sequence and data.
module tb_rom_arbiter;
   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        cpu_req = 1'b0, dma_req = 1'b0;
   logic [15:0] cpu_addr = '0, dma_addr = '0;
   logic        cpu_word = 1'b0, dma_word = 1'b0;
   logic        cpu_done, dma_done, rom_en, busy;
   logic [31:0] cpu_rdata, dma_rdata;
   logic [15:0] rom_addr;
   logic [15:0] rom_dout = '0;
   logic [15:0] mem [0:65535];
   int          n_tests = 0, n_fail = 0;
   logic        last = 1'b1;
   logic        w;
   logic        any;
   logic [31:0] got;

   rom_arbiter #(.ADDR_W(16)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_word(dma_word),
      .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .dma_done(dma_done), .dma_rdata(dma_rdata),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (rom_en) rom_dout <= mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] swap(input logic [15:0] h);
      return {h[7:0], h[15:8]};
   endfunction

   // Called at the start of an IDLE cycle with requests already driven; returns
   // at the start of the IDLE cycle that follows the response.
   task automatic txn(output logic winner, output logic served, output logic [31:0] rd);
      logic [15:0] a, a1;
      logic wd, cd, dd;
      logic [31:0] exp;
      int lat;
      rd = 32'h0;
      served = cpu_req | dma_req;
      winner = 1'b0;
      if (!served) begin
         @(negedge CLK);
         check("idle_busy", {31'h0, busy}, 32'h0);
         check("idle_done", {30'h0, cpu_done, dma_done}, 32'h0);
         @(posedge CLK); #1;
         return;
      end
`ifdef ROM_ARB_ROUND_ROBIN_EN
      winner = (cpu_req && dma_req) ? ~last : dma_req;
`else
      winner = ~cpu_req;
`endif
      last = winner;
      a  = winner ? dma_addr : cpu_addr;
      wd = winner ? dma_word : cpu_word;
      a1 = a + 16'd1;
      exp = wd ? {swap(mem[a1]), swap(mem[a])} : {16'h0, swap(mem[a])};
      lat = wd ? 4 : 3;
      for (int k = 1; k <= lat; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         cd = (k == lat) && !winner;
         dd = (k == lat) && winner;
         check("busy", {31'h0, busy}, 32'h1);
         check("cpu_done", {31'h0, cpu_done}, {31'h0, cd});
         check("dma_done", {31'h0, dma_done}, {31'h0, dd});
         check("cpu_rdata", cpu_rdata, cd ? exp : 32'h0);
         check("dma_rdata", dma_rdata, dd ? exp : 32'h0);
         if (k == 1) begin
            check("rom_addr1", {16'h0, rom_addr}, {16'h0, a});
            check("rom_en1", {31'h0, rom_en}, 32'h1);
         end
         if (k == 2) begin
            check("rom_addr2", {16'h0, rom_addr}, {16'h0, wd ? a1 : a});
            check("rom_en2", {31'h0, rom_en}, {31'h0, wd});
         end
         if (k >= 3) check("rom_en3", {31'h0, rom_en}, 32'h0);
         if (k == lat) rd = winner ? dma_rdata : cpu_rdata;
      end
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_rom_en", {31'h0, rom_en}, 32'h0);
      check("rst_rom_addr", {16'h0, rom_addr}, 32'h0);
      check("rst_done", {30'h0, cpu_done, dma_done}, 32'h0);
      check("rst_rdata", cpu_rdata | dma_rdata, 32'h0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      last = 1'b1;
   endtask

   task automatic new_req(input logic who);
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if (who) begin
         dma_req = 1'b1; dma_addr = a; dma_word = 1'($urandom);
      end else begin
         cpu_req = 1'b1; cpu_addr = a; cpu_word = 1'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h0010] = 16'h1234;
      mem[16'h0020] = 16'hAABB;
      mem[16'h0021] = 16'hCCDD;
      mem[16'hFFFF] = 16'h5566;
      mem[16'h0000] = 16'h7788;
      do_reset();

      cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_word = 1'b0;
      txn(w, any, got);
      check("cpu_half_data", got, 32'h00003412);
      cpu_req = 1'b0;

      dma_req = 1'b1; dma_addr = 16'h0020; dma_word = 1'b1;
      txn(w, any, got);
      check("dma_word_data", got, 32'hDDCCBBAA);
      dma_req = 1'b0;

      cpu_req = 1'b1; cpu_addr = 16'hFFFF; cpu_word = 1'b1;
      txn(w, any, got);
      check("wrap_data", got, 32'h88776655);
      cpu_req = 1'b0;

      do_reset();
      cpu_req = 1'b1; cpu_addr = 16'h0100; cpu_word = 1'b1;
      dma_req = 1'b1; dma_addr = 16'h0200; dma_word = 1'b1;
      for (int t = 0; t < 3; t++) begin
         txn(w, any, got);
`ifdef ROM_ARB_ROUND_ROBIN_EN
         check("rr_grant", {31'h0, w}, t[31:0] & 32'h1);
`else
         check("fixed_grant", {31'h0, w}, 32'h0);
`endif
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      txn(w, any, got);

      cpu_req = 1'b1; cpu_addr = 16'h0020; cpu_word = 1'b1;
      @(posedge CLK);
      @(posedge CLK); #1;
      RESET_N = 1'b0;
      cpu_req = 1'b0;
      @(negedge CLK);
      check("abort_busy_before", {31'h0, busy}, 32'h1);
      @(posedge CLK);
      @(negedge CLK);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_rom_en", {31'h0, rom_en}, 32'h0);
      check("abort_done", {30'h0, cpu_done, dma_done}, 32'h0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      last = 1'b1;
      cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_word = 1'b0;
      txn(w, any, got);
      check("post_abort_data", got, 32'h00003412);
      cpu_req = 1'b0;

      for (int it = 0; it < 400; it++) begin
         txn(w, any, got);
         if (any) begin
            if ($urandom_range(0, 3) == 0) begin
               if (w) dma_req = 1'b0; else cpu_req = 1'b0;
            end else new_req(w);
            if (w ? !cpu_req : !dma_req) begin
               if ($urandom_range(0, 1) == 1) new_req(~w);
            end
         end else begin
            if ($urandom_range(0, 1) == 1) new_req(1'b0);
            if ($urandom_range(0, 1) == 1) new_req(1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
